// File: rtl/core_pkg.sv
// Shared core types and constants: PC width, boot address, fetch queue entry.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order queue of fetched instructions with push/pop/clear.
// Push and pop may occur together at any occupancy, including when full.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so push is allowed when full and popping
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy tracking; clear empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Entry storage, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && full && !pop && !clear));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty && !clear));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order
// requests, drops wrong-path responses after a flush, and buffers returned
// instructions for decode.
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CNT_W  = $clog2(2 * DEPTH + 1);
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;

  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;

  logic [CNT_W-1:0]  in_flight;
  logic              pop;
  logic              push;
  logic              accept;
  logic              dropping;
  logic              credit_ok;

  // Credit: a request is allowed only while accepted-but-unconsumed work
  // (after this cycle's pop) stays below the queue depth
  always_comb begin
    in_flight      = outstanding + CNT_W'(fifo_count);
    pop            = inst_valid & ~fetch_stall & ~flush;
    credit_ok      = (in_flight - CNT_W'(pop)) < CNT_W'(DEPTH);
    imem_req_valid = ~reset & ~flush & credit_ok;
    imem_req_addr  = reset ? '0 : pc;
    accept         = imem_req_valid & imem_req_ready;
    dropping       = imem_resp_valid & (drop_cnt != '0);
    push           = imem_resp_valid & (drop_cnt == '0) & ~flush;
    push_entry     = '{pc: resp_pc, inst: imem_resp_data};
  end

  // Head of queue presented to decode, zeroed when nothing is valid
  always_comb begin
    inst_valid = ~reset & ~fifo_empty;
    inst       = inst_valid ? fifo_head.inst : '0;
    inst_pc    = inst_valid ? fifo_head.pc   : '0;
  end

  // PC, credit and wrong-path drop bookkeeping; resp_pc tracks the address
  // of the oldest outstanding request that will actually be kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_resp_valid);
      if (flush) begin
        pc       <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding - CNT_W'(imem_resp_valid);
      end else begin
        if (accept)   pc       <= pc + XLEN'(4);
        if (push)     resp_pc  <= resp_pc + XLEN'(4);
        if (dropping) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (flush),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_resp_has_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (outstanding != '0));

  a_credit_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with configurable latency and
// a scoreboard of expected {pc, inst} pairs consumed as decode pops them.
module tb_fetch_unit;
  import core_pkg::*;

  logic            clk;
  logic            reset;
  logic            fetch_stall;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            inst_valid;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  fetch_unit #(.DEPTH(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_stall     (fetch_stall),
    .flush           (flush),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mem_q[$];
  fetch_entry_t sb[$];
  logic [31:0]  pop_log[$];

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          k;
  int          first_iv;
  logic [31:0] pc_model;
  logic [31:0] last_acc;
  logic        have_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive the memory response, sample at negedge, update models
  task automatic step();
    fetch_entry_t e;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom();
    end
    @(negedge clk);
    if (flush) check("flush_no_req", 32'(imem_req_valid), 32'd0);
    if (inst_valid && first_iv == 0) first_iv = cyc;
    if (!inst_valid) begin
      check("idle_inst", inst, 32'd0);
      check("idle_pc", inst_pc, 32'd0);
    end
    if (inst_valid && !fetch_stall && !flush) begin
      if (sb.size() == 0) begin
        check("pop_with_empty_sb", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.inst);
        pop_log.push_back(inst_pc);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, pc_model);
      if (have_last && last_acc == 32'hFFFF_FFFC) check("wrap_addr", imem_req_addr, 32'd0);
      last_acc  = pc_model;
      have_last = 1'b1;
      mem_q.push_back('{imem_req_addr, cyc + k});
      sb.push_back('{pc: pc_model, inst: mem_data(pc_model)});
      pc_model = pc_model + 32'd4;
    end
    if (flush) begin
      sb.delete();
      pc_model = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"}, imem_req_addr, 32'd0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_pc"}, inst_pc, 32'd0);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
    if (pop_log.size() > idx) check(tag, pop_log[idx], exp);
    else check({tag, "_missing"}, 32'(pop_log.size()), 32'(idx + 1));
  endtask

  initial begin
    int base;
    logic [31:0] stall_pc;
    logic [31:0] hold;
    n_checks = 0; n_fail = 0; cyc = 0; k = 1; first_iv = 0;
    pc_model = RESET_PC; last_acc = '0; have_last = 1'b0;
    reset = 1'b1; fetch_stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;

    // Reset and first request
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc = 1;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    // Streaming, k=1, no stall
    repeat (8) step();
    check("first_inst_cycle", 32'(first_iv), 32'd3);
    check_log("stream_pc0", 0, 32'h0);
    check_log("stream_pc1", 1, 32'h4);
    check_log("stream_pc2", 2, 32'h8);

    // Decode stall saturates the credit
    fetch_stall = 1'b1;
    stall_pc = sb[0].pc;
    repeat (5) begin
      step();
      check("stall_head", inst_pc, stall_pc);
    end
    check("stall_credit", 32'(imem_req_valid), 32'd0);
    fetch_stall = 1'b0;
    repeat (4) step();

    // Memory not ready holds the address
    imem_req_ready = 1'b0;
    hold = pc_model;
    repeat (3) begin
      step();
      check("hold_addr", imem_req_addr, hold);
    end
    imem_req_ready = 1'b1;
    repeat (3) step();

    // Flush with two requests outstanding, k=3
    k = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
    check("two_outstanding", 32'(mem_q.size()), 32'd2);
    base = pop_log.size();
    redirect_pc = 32'h100;
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (12) step();
    check_log("flush_pc0", base, 32'h100);
    check_log("flush_pc1", base + 1, 32'h104);

    // Back-to-back flushes: last redirect wins
    base = pop_log.size();
    redirect_pc = 32'h200;
    flush = 1'b1;
    step();
    redirect_pc = 32'h300;
    step();
    flush = 1'b0;
    repeat (12) step();
    check_log("b2b_pc0", base, 32'h300);
    check_log("b2b_pc1", base + 1, 32'h304);

    // Flush in the same cycle as a response, k=1
    k = 1;
    repeat (6) step();
    redirect_pc = 32'h400;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("post_flush_iv", 32'(inst_valid), 32'd0);
    base = pop_log.size();
    repeat (6) step();
    check_log("resp_flush_pc0", base, 32'h400);

    // PC wrap at the top of the address space
    redirect_pc = 32'hFFFF_FFF8;
    flush = 1'b1;
    step();
    flush = 1'b0;
    base = pop_log.size();
    repeat (8) step();
    check_log("wrap_pc0", base, 32'hFFFF_FFF8);
    check_log("wrap_pc1", base + 1, 32'hFFFF_FFFC);
    check_log("wrap_pc2", base + 2, 32'h0000_0000);

    // Reset in the middle of traffic
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    mem_q.delete();
    sb.delete();
    pc_model = RESET_PC;
    have_last = 1'b0;
    imem_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    base = pop_log.size();
    repeat (6) step();
    check_log("after_reset_pc0", base, RESET_PC);

    // Drain everything with no new requests
    imem_req_ready = 1'b0;
    repeat (10) step();
    check("drain_sb", 32'(sb.size()), 32'd0);
    check("drain_iv", 32'(inst_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the core: owns the PC, issues in-order requests to instruction memory with a credit limit, buffers returned instructions in a 2-entry queue, and presents them to decode. It sits directly upstream of the core control logic. That logic supplies `fetch_stall` (decode cannot accept) and `flush` (redirect); this block discards all wrong-path work on `flush`.

## Interface
- `XLEN`, 32: address/PC width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: max instructions in flight (outstanding + buffered); queue depth.

- `clk`  in  1  core clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_stall`  in  1  decode does not accept the head instruction this cycle.
- `flush`  in  1  discard all in-flight/buffered instructions and redirect.
- `redirect_pc`  in  XLEN  new fetch address, sampled when `flush`=1.
- `imem_req_valid`  out  1  request valid.
- `imem_req_addr`  out  XLEN  request address (= PC register).
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  response valid; in order; never back-pressured.
- `imem_resp_data`  in  32  instruction word.
- `inst_valid`  out  1  head instruction available to decode.
- `inst`  out  32  head instruction; 0 when `inst_valid`=0.
- `inst_pc`  out  XLEN  PC of head instruction; 0 when `inst_valid`=0.

## Operation
- State: `pc`, `outstanding` (accepted requests not yet answered), queue of {pc, inst} with `count`, `drop_cnt` (responses still owed from before a flush).
- `in_flight = outstanding + count`; `pop = inst_valid & ~fetch_stall & ~flush`.
- `imem_req_valid = ~flush & (in_flight - pop < DEPTH)`; `imem_req_addr = pc`.
- Request accepted (`valid & ready`): `pc <= pc + 4` (wraps modulo 2^XLEN); `outstanding` +1.
- Response: `outstanding` −1. If `drop_cnt`>0, discard it and decrement `drop_cnt`. Otherwise push {pc-of-request, data}; the request PC comes from a PC tag queue of depth `DEPTH` or is derived as head PC + 4·position.
- Push and pop in the same cycle are legal at any occupancy. With the credit rule, overflow is impossible; an overflow is an assertion failure.
- `flush`: queue cleared; `pc <= redirect_pc`; no request issued that cycle; `drop_cnt <= outstanding - (imem_resp_valid ? 1 : 0)` plus existing `drop_cnt` accounting, so every pre-flush response is dropped, including one arriving in the flush cycle.
- `flush` with `fetch_stall`: flush wins; no pop.
- Back-to-back flushes: the last `redirect_pc` wins; drop accounting accumulates correctly.

## Timing
- Reset (async assert): `pc=RESET_PC`, queue empty, `outstanding=0`, `drop_cnt=0`. All outputs 0 while `reset` is high.
- First request: `imem_req_valid`=1 in the first cycle after `reset` deasserts, with `imem_req_addr=RESET_PC`.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1), `inst_valid` in cycle N+k+1. The queue is registered, with no response→decode bypass.
- Steady state with k=1 and no stall: one instruction per cycle.
- After `flush` in cycle F: the first request to `redirect_pc` goes out in F+1. `inst_valid`=0 in F+1 at the earliest.
- Responses owed to `drop_cnt` never appear on `inst`.
- `reset` asserted mid-operation: all state is cleared immediately. The memory must not return responses for pre-reset requests.

## Structure
- Shared package `core_pkg`: `XLEN`, `RESET_PC`, and typedef `fetch_entry_t` {pc, inst}. Decode reuses these.
- Sub-module `fetch_fifo`: parameterised `DEPTH`-entry queue of `fetch_entry_t` with push/pop/clear, `count`, full/empty. The top level holds the PC, credit, and drop logic.
- Expected size: ~200 lines total.

## Test plan
- Reset, memory k=1, `imem_req_ready`=1, no stall → addresses 0,4,8,… on consecutive cycles. `inst_valid` first high in cycle 3 after reset. `inst_pc`=0,4,8 with matching data.
- Hold `fetch_stall`=1 for 5 cycles → `in_flight` saturates at 2. `imem_req_valid` drops. Head stays at the same PC. Release resumes with no duplicated or lost PC.
- `imem_req_ready`=0 for 3 cycles → `imem_req_addr` held stable. `pc` does not advance.
- With 2 outstanding (k=3), `flush` with `redirect_pc`=0x100 → both old responses are dropped. The next `inst_pc` is 0x100, followed by 0x104.
- `flush` coincides with `imem_resp_valid` and `fetch_stall`=0 → that response is dropped. No pop occurs. `inst_valid`=0 in the following cycle.
- `pc`=0xFFFF_FFFC → the next request address wraps to 0x0000_0000.
